// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port (A read-only, B read/write) arbiter in front of a single-port synchronous RAM.
//
// Parameters: WIDTH (data width), ADDR (address width), LOCK_MAX (max consecutive locked B grants).
// Ports:
//   CLK, RESET_N                      clock, asynchronous active-low reset
//   A_REQ, A_ADDR                     requester A (instruction fetch, read only)
//   A_GNT, A_VALID, A_Q               A grant (comb), response strobe, read data
//   B_REQ, B_WREN, B_ADDR, B_DATA,    requester B (load/store)
//   B_LOCK                            B lock request (ignored unless RAM_ARB_LOCK_EN)
//   B_GNT, B_VALID, B_Q               B grant (comb), response strobe, read data / write ack data
//   RAM_ADDRESS, RAM_DATA, RAM_WREN   RAM inputs, registered by the RAM on CLK
//   RAM_Q                             RAM read data, valid the cycle after the access
// Build option: define RAM_ARB_LOCK_EN to compile in the B lock FSM; otherwise pure round-robin.
module ram_arbiter #(
    parameter int WIDTH    = 16,
    parameter int ADDR     = 8,
    parameter int LOCK_MAX = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             A_REQ,
    input  logic [ADDR-1:0]  A_ADDR,
    output logic             A_GNT,
    output logic             A_VALID,
    output logic [WIDTH-1:0] A_Q,
    input  logic             B_REQ,
    input  logic             B_WREN,
    input  logic [ADDR-1:0]  B_ADDR,
    input  logic [WIDTH-1:0] B_DATA,
    input  logic             B_LOCK,
    output logic             B_GNT,
    output logic             B_VALID,
    output logic [WIDTH-1:0] B_Q,
    output logic [ADDR-1:0]  RAM_ADDRESS,
    output logic [WIDTH-1:0] RAM_DATA,
    output logic             RAM_WREN,
    input  logic [WIDTH-1:0] RAM_Q
);

    logic             locked;
    logic             a_gnt;
    logic             b_gnt;
    logic             last_b_q, last_b_d;
    logic [ADDR-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             a_own_q, a_own_d;
    logic             b_own_q, b_own_d;
    logic             b_wr_q, b_wr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] a_q_q, a_q_d;
    logic [WIDTH-1:0] b_q_q, b_q_d;

    // Grants are gated by RESET_N so they drop the instant reset asserts.
    // last_b_q set means B was served most recently, so A wins a contested cycle.
    always_comb begin
        a_gnt       = RESET_N & A_REQ & ~locked & (~B_REQ | last_b_q);
        b_gnt       = RESET_N & B_REQ & (locked | ~A_REQ | ~last_b_q);
        A_GNT       = a_gnt;
        B_GNT       = b_gnt;
        RAM_ADDRESS = a_gnt ? A_ADDR : (b_gnt ? B_ADDR : addr_q);
        RAM_DATA    = b_gnt ? B_DATA : data_q;
        RAM_WREN    = b_gnt & B_WREN;
        addr_d      = RAM_ADDRESS;
        data_d      = RAM_DATA;
        last_b_d    = b_gnt ? 1'b1 : (a_gnt ? 1'b0 : last_b_q);
        a_own_d     = a_gnt;
        b_own_d     = b_gnt;
        b_wr_d      = b_gnt & B_WREN;
        wdata_d     = B_DATA;
    end

    // Responses: the owner flops mark whose access is returning this cycle.
    // A write acknowledges with the data it wrote rather than RAM_Q.
    always_comb begin
        A_VALID = a_own_q;
        B_VALID = b_own_q;
        A_Q     = a_own_q ? RAM_Q : a_q_q;
        B_Q     = b_own_q ? (b_wr_q ? wdata_q : RAM_Q) : b_q_q;
        a_q_d   = A_Q;
        b_q_d   = B_Q;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            last_b_q <= 1'b1;
            addr_q   <= '0;
            data_q   <= '0;
            a_own_q  <= 1'b0;
            b_own_q  <= 1'b0;
            b_wr_q   <= 1'b0;
            wdata_q  <= '0;
            a_q_q    <= '0;
            b_q_q    <= '0;
        end else begin
            last_b_q <= last_b_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            a_own_q  <= a_own_d;
            b_own_q  <= b_own_d;
            b_wr_q   <= b_wr_d;
            wdata_q  <= wdata_d;
            a_q_q    <= a_q_d;
            b_q_q    <= b_q_d;
        end
    end

`ifdef RAM_ARB_LOCK_EN
    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;
    localparam int CW = $clog2(LOCK_MAX + 1);

    lock_state_t   lock_state_q, lock_state_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            lock_state_q <= UNLOCKED;
            lock_cnt_q   <= '0;
        end else begin
            lock_state_q <= lock_state_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end

    // Only B grants move the lock. The grant that brings the count to LOCK_MAX
    // releases the lock; last-served is then B, so a waiting A wins next.
    always_comb begin
        lock_state_d = lock_state_q;
        lock_cnt_d   = lock_cnt_q;
        if (b_gnt) begin
            if (lock_state_q == UNLOCKED) begin
                if (B_LOCK && LOCK_MAX > 1) begin
                    lock_state_d = LOCKED;
                    lock_cnt_d   = CW'(1);
                end
            end else if (!B_LOCK || lock_cnt_q == CW'(LOCK_MAX - 1)) begin
                lock_state_d = UNLOCKED;
                lock_cnt_d   = '0;
            end else begin
                lock_cnt_d   = lock_cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        locked = (lock_state_q == LOCKED);
    end
`else
    logic unused_lock;

    assign locked      = 1'b0;
    assign unused_lock = B_LOCK;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized and directed self-checking bench for ram_arbiter against a behavioural model.
module tb_ram_arbiter;

    localparam int W  = 16;
    localparam int AW = 8;
    localparam int LM = 8;
`ifdef RAM_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_req, a_gnt, a_valid;
    logic [AW-1:0] a_addr;
    logic [W-1:0]  a_q;
    logic          b_req, b_wren, b_lock, b_gnt, b_valid;
    logic [AW-1:0] b_addr;
    logic [W-1:0]  b_data, b_q;
    logic [AW-1:0] ram_address;
    logic [W-1:0]  ram_data, ram_q;
    logic          ram_wren;

    logic [W-1:0]  mem [1<<AW];
    logic [W-1:0]  ref_mem [1<<AW];

    int            passed = 0;
    int            total = 0;
    int            last_w = 0;
    int            m_last, m_run, m_owner;
    bit            m_lk;
    logic [W-1:0]  m_resp, m_aq, m_bq, m_data_h;
    logic [AW-1:0] m_addr_h;

    always #5 clk = ~clk;

    ram_arbiter #(.WIDTH(W), .ADDR(AW), .LOCK_MAX(LM)) dut (
        .CLK(clk), .RESET_N(rst_n),
        .A_REQ(a_req), .A_ADDR(a_addr), .A_GNT(a_gnt), .A_VALID(a_valid), .A_Q(a_q),
        .B_REQ(b_req), .B_WREN(b_wren), .B_ADDR(b_addr), .B_DATA(b_data), .B_LOCK(b_lock),
        .B_GNT(b_gnt), .B_VALID(b_valid), .B_Q(b_q),
        .RAM_ADDRESS(ram_address), .RAM_DATA(ram_data), .RAM_WREN(ram_wren), .RAM_Q(ram_q)
    );

    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_last = 2; m_lk = 0; m_run = 0; m_owner = 0;
        m_aq = '0; m_bq = '0; m_addr_h = '0; m_data_h = '0;
    endtask

    // 0 = nobody, 1 = A, 2 = B
    function automatic int pick();
        if (m_lk) return b_req ? 2 : 0;
        if (a_req && b_req) return (m_last == 2) ? 1 : 2;
        if (a_req) return 1;
        if (b_req) return 2;
        return 0;
    endfunction

    task automatic reset_checks();
        #1;
        check("rst_a_gnt", a_gnt, 0);
        check("rst_b_gnt", b_gnt, 0);
        check("rst_a_valid", a_valid, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_wren", ram_wren, 0);
        check("rst_addr", ram_address, 0);
        check("rst_data", ram_data, 0);
        check("rst_a_q", a_q, 0);
        check("rst_b_q", b_q, 0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;
        last_w = 0;
    endtask

    // One access cycle: entered at a falling edge with inputs applied, leaves at the next falling edge.
    task automatic cycle(input bit rst_mid);
        int w;
        #1;
        w = pick();
        check("a_gnt", a_gnt, w == 1);
        check("b_gnt", b_gnt, w == 2);
        check("ram_wren", ram_wren, w == 2 && b_wren);
        check("ram_addr", ram_address, w == 1 ? a_addr : (w == 2 ? b_addr : m_addr_h));
        check("ram_data", ram_data, w == 2 ? b_data : m_data_h);
        @(posedge clk);
        last_w = w;
        if (rst_mid) begin
            #2;
            rst_n = 1'b0;
            model_reset();
        end else begin
            m_owner = w;
            if (w == 1) begin
                m_resp = ref_mem[a_addr];
                m_addr_h = a_addr;
            end
            if (w == 2) begin
                m_resp = b_wren ? b_data : ref_mem[b_addr];
                if (b_wren) ref_mem[b_addr] = b_data;
                m_addr_h = b_addr;
                m_data_h = b_data;
                if (LOCK_EN) begin
                    if (!m_lk) begin
                        if (b_lock) begin m_lk = 1; m_run = 1; end
                    end else if (!b_lock) m_lk = 0;
                    else begin
                        m_run++;
                        if (m_run == LM) m_lk = 0;
                    end
                end
            end
            if (w != 0) m_last = w;
        end
        @(negedge clk);
        if (m_owner == 1) m_aq = m_resp;
        if (m_owner == 2) m_bq = m_resp;
        check("a_valid", a_valid, m_owner == 1);
        check("b_valid", b_valid, m_owner == 2);
        check("a_q", a_q, m_aq);
        check("b_q", b_q, m_bq);
    endtask

    task automatic drive_random();
        if (!a_req || last_w == 1) begin
            a_req  = $urandom_range(0, 3) != 0;
            a_addr = AW'($urandom_range(0, 15));
        end
        if (!b_req || last_w == 2) begin
            b_req  = $urandom_range(0, 3) != 0;
            b_wren = $urandom_range(0, 1) == 1;
            b_addr = AW'($urandom_range(0, 15));
            b_data = W'($urandom);
            b_lock = $urandom_range(0, 3) != 0;
        end
    endtask

    initial begin
        int n;
        a_req = 0; a_addr = '0; b_req = 0; b_wren = 0; b_addr = '0; b_data = '0; b_lock = 0;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = W'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[16] = 16'hBEEF;
        ref_mem[16] = 16'hBEEF;
        model_reset();
        @(negedge clk);
        apply_reset();

        a_req = 1; a_addr = 8'h10;
        cycle(0);
        check("a_q_beef", a_q, 16'hBEEF);
        a_req = 0;

        b_req = 1; b_wren = 1; b_addr = 8'h20; b_data = 16'h1234;
        cycle(0);
        b_wren = 0; b_data = 16'h5555;
        cycle(0);
        check("b_raw", b_q, 16'h1234);
        b_req = 0;

        apply_reset();
        a_req = 1; b_req = 1; b_wren = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(0);
            check("alternate", last_w, (i % 2 == 0) ? 1 : 2);
        end

        a_req = 0; b_req = 0;
        apply_reset();
        b_req = 1; b_lock = 1;
        cycle(0);
        a_req = 1;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            cycle(0);
            if (last_w != 2) break;
            n++;
        end
        check("lock_run", n, LOCK_EN ? LM : 1);
        check("a_after_lock", last_w, 1);

        a_req = 0; b_req = 0;
        apply_reset();
        b_req = 1; b_lock = 1;
        cycle(0);
        a_req = 1; b_lock = 0;
        cycle(0);
        check("unlock_first", last_w, LOCK_EN ? 2 : 1);
        cycle(0);
        check("unlock_second", last_w, LOCK_EN ? 1 : 2);

        a_req = 0; b_req = 0;
        apply_reset();
        b_req = 1; b_wren = 0; b_addr = 8'h05;
        cycle(1);
        a_req = 1; b_req = 1;
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0);
        check("first_after_rst", last_w, 1);

        for (int i = 0; i < 400; i++) begin
            drive_random();
            cycle(0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
